// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial, LSB-first WIDTH-bit subtractor (diff = a - b).
// Handshake: start (operands sampled on the same edge) -> busy for WIDTH cycles
// -> one-cycle done with diff/borrow valid.
// Optional: define SERIAL_SUB_OVERFLOW_EN to add the signed-overflow output ovf.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef SERIAL_SUB_OVERFLOW_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             br_q, br_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    logic a0, b0, dbit, br_next, last_bit;

    // Full-subtractor slice on the current LSBs plus the borrow flop
    always_comb begin
        a0       = a_q[0];
        b0       = b_q[0];
        dbit     = a0 ^ b0 ^ br_q;
        br_next  = (~a0 & b0) | (~(a0 ^ b0) & br_q);
        last_bit = (cnt_q == CW'(WIDTH - 1));
    end

    // Next-state, datapath updates and handshake outputs
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        busy     = 1'b0;
        done     = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (state_q == DONE) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
                // DONE accepts a new start directly for back-to-back throughput
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = b;
                    res_d   = '0;
                    cnt_d   = '0;
                    br_d    = 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                end
            end
            RUN: begin
                busy  = 1'b1;
                res_d = {dbit, res_q[WIDTH-1:1]};
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                br_d  = br_next;
                cnt_d = last_bit ? '0 : cnt_q + CW'(1);
                if (last_bit) begin
                    state_d  = DONE;
                    diff_d   = {dbit, res_q[WIDTH-1:1]};
                    borrow_d = br_next;
`ifdef SERIAL_SUB_OVERFLOW_EN
                    ovf_d    = (a_msb_q != b_msb_q) && (dbit != a_msb_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8); reference model uses
// plain integer arithmetic on the operands.
module tb_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       busy, done, borrow;
    logic [7:0] diff;
`ifdef SERIAL_SUB_OVERFLOW_EN
    logic       ovf;
`endif

    int compared   = 0;
    int mismatched = 0;

    // Last completed result as seen by the model
    logic [7:0] prev_diff   = '0;
    logic       prev_borrow = 1'b0;
    logic       prev_ovf    = 1'b0;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef SERIAL_SUB_OVERFLOW_EN
        ,
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_results(input string tag);
        check({tag, "_diff"}, 32'(diff), 32'(prev_diff));
        check({tag, "_borrow"}, 32'(borrow), 32'(prev_borrow));
`ifdef SERIAL_SUB_OVERFLOW_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(prev_ovf));
`endif
    endtask

    // One full operation; if poke is 1..8 a spurious start with 0xAA/0x55 is
    // driven during that busy cycle. Returns during the done cycle.
    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib, input int poke);
        int sa, sb, r;
        a = ia; b = ib; start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'($urandom); b = 8'($urandom);
        for (int c = 1; c <= 8; c++) begin
            if (c == poke) begin
                start = 1'b1; a = 8'hAA; b = 8'h55;
            end
            check("run_busy", 32'(busy), 32'd1);
            check("run_done", 32'(done), 32'd0);
            check_results("run_hold");
            tick();
            start = 1'b0;
        end
        prev_diff   = 8'((int'(ia) - int'(ib)) & 255);
        prev_borrow = (ia < ib);
        sa = (ia >= 128) ? int'(ia) - 256 : int'(ia);
        sb = (ib >= 128) ? int'(ib) - 256 : int'(ib);
        r  = sa - sb;
        prev_ovf = (r > 127) || (r < -128);
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check_results("result");
    endtask

    // One idle cycle after a done: pulse must be gone, results held
    task automatic idle();
        tick();
        check("idle_done", 32'(done), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);
        check_results("idle_hold");
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check_results("rst");
        rst = 1'b0;
        tick();

        // Directed cases
        do_op(8'h05, 8'h03, 0); idle();
        do_op(8'h03, 8'h05, 0); idle();
        do_op(8'h00, 8'h00, 0); idle();
        do_op(8'hFF, 8'h01, 0); idle();
        do_op(8'h80, 8'h01, 0); idle();
        do_op(8'h10, 8'h01, 3); idle();
        check("ignored_diff", 32'(diff), 32'h0F);

        // Abort with reset in cycle 4 of a run
        a = 8'h20; b = 8'h10; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        prev_diff = '0; prev_borrow = 1'b0; prev_ovf = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check_results("abort");
        for (int i = 0; i < 10; i++) begin
            check("abort_no_done", 32'(done), 32'd0);
            tick();
        end

        // Reset wins over start on the same edge
        rst = 1'b1; start = 1'b1; a = 8'h33; b = 8'h11;
        tick();
        rst = 1'b0; start = 1'b0;
        check("rst_prio_busy", 32'(busy), 32'd0);
        tick();
        check("rst_prio_idle", 32'(busy), 32'd0);

        // Back-to-back from the done cycle
        do_op(8'h09, 8'h09, 0);
        do_op(8'h80, 8'h7F, 0);
        check("b2b_diff", 32'(diff), 32'h01);
        idle();

        // Randomized operations with random gaps and spurious starts
        for (int n = 0; n < 30; n++) begin
            do_op(8'($urandom), 8'($urandom), ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 8)) : 0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
